// File: rtl/mean_sched_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mean_sched_pkg
// Brief    : Shared types and width helpers for the mean-engine scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package mean_sched_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STREAM   = 2'd1,
    WAIT_RES = 2'd2
  } state_t;

  // Channel index width, never narrower than one bit.
  function automatic int ch_w(input int nch);
    return (nch > 2) ? $clog2(nch) : 1;
  endfunction

  // Samples per frame for a given log2 frame length.
  function automatic int frame_len(input int n);
    return 1 << n;
  endfunction

  // Frame sample counter width, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? n : 1;
  endfunction

  // Result-timeout counter width, never narrower than one bit.
  function automatic int tcnt_w(input int timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mean_sched_if.sv
`default_nettype none
// ============================================================================
// Interface : mean_sched_if
// Brief     : Requester, mean-engine and result signals of the scheduler.
//             The master modport is the scheduler side, slave the environment.
// Revision  : 1.0 - initial release
// ============================================================================
interface mean_sched_if
  import mean_sched_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NCH   = 4
) ();

  localparam int CH_W = ch_w(NCH);

  // Per-channel requesters
  logic [NCH-1:0]       req_vld;
  logic [NCH*WIDTH-1:0] req_data;
  logic [NCH-1:0]       req_rdy;

  // Mean engine
  logic                 m_i_vld;
  logic [WIDTH-1:0]     m_i_data;
  logic                 m_o_vld;
  logic [WIDTH-1:0]     m_o_data;

  // Tagged result and status
  logic                 res_vld;
  logic [CH_W-1:0]      res_ch;
  logic [WIDTH-1:0]     res_data;
  logic                 busy;
  logic                 err;

  modport master (
    input  req_vld, req_data, m_o_vld, m_o_data,
    output req_rdy, m_i_vld, m_i_data, res_vld, res_ch, res_data, busy, err
  );

  modport slave (
    output req_vld, req_data, m_o_vld, m_o_data,
    input  req_rdy, m_i_vld, m_i_data, res_vld, res_ch, res_data, busy, err
  );

endinterface
`default_nettype wire

// File: rtl/mean_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick. Scans requests starting one
//            above the last served channel, wrapping at NCH.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import mean_sched_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int CH_W = ch_w(NCH)
) (
  input  logic [NCH-1:0]  req_i,
  input  logic [CH_W-1:0] last_i,
  output logic            any_o,
  output logic [CH_W-1:0] gnt_o
);

  logic [2*NCH-1:0] w_req2;
  logic [CH_W:0]    w_sh;
  logic [NCH-1:0]   w_rot;
  logic [CH_W:0]    w_off;
  logic [CH_W+1:0]  w_sum;

  // Rotate requests so bit 0 is the highest-priority channel, find the first
  // set bit, then map that offset back to an absolute channel number.
  always_comb begin
    w_req2 = {req_i, req_i};
    w_sh   = {1'b0, last_i} + (CH_W+1)'(1);
    w_rot  = NCH'(w_req2 >> w_sh);
    w_off  = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = (CH_W+1)'(i);
      end
    end
    w_sum = {1'b0, w_sh} + {1'b0, w_off};
    if (w_sum >= (CH_W+2)'(NCH)) begin
      w_sum = w_sum - (CH_W+2)'(NCH);
    end
    any_o = |req_i;
    gnt_o = w_sum[CH_W-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/mean_sched.sv
`default_nettype none
// ============================================================================
// Module   : mean_sched
// Brief    : Round-robin scheduler sharing one windowed mean engine between
//            NCH requesters. A granted channel streams a full frame of 2**N
//            samples, then the engine result is returned tagged with the
//            channel index.
// Revision : 1.0 - initial release
// ============================================================================
module mean_sched
  import mean_sched_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int N       = 1,
  parameter int NCH     = 4,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rstn,
  mean_sched_if.master  bus
);

  localparam int CH_W = ch_w(NCH);
  localparam int L    = frame_len(N);
  localparam int CW   = cnt_w(N);
  localparam int TW   = tcnt_w(TIMEOUT);

  state_t            state_q,    state_d;
  logic [CH_W-1:0]   gnt_q,      gnt_d;
  logic [CH_W-1:0]   rr_q,       rr_d;
  logic [CW-1:0]     cnt_q,      cnt_d;
  logic [TW-1:0]     tcnt_q,     tcnt_d;
  logic              m_i_vld_q,  m_i_vld_d;
  logic [WIDTH-1:0]  m_i_data_q, m_i_data_d;
  logic              res_vld_q,  res_vld_d;
  logic [WIDTH-1:0]  res_data_q, res_data_d;
  logic [CH_W-1:0]   res_ch_q,   res_ch_d;
  logic              err_q,      err_d;

  logic              w_any;
  logic [CH_W-1:0]   w_arb_gnt;
  logic [WIDTH-1:0]  w_ch_data [NCH];
  logic              w_sel_vld;
  logic [WIDTH-1:0]  w_sel_data;
  logic [NCH-1:0]    w_onehot;

  rr_arbiter #(
    .NCH  (NCH),
    .CH_W (CH_W)
  ) u_rr_arbiter (
    .req_i  (bus.req_vld),
    .last_i (rr_q),
    .any_o  (w_any),
    .gnt_o  (w_arb_gnt)
  );

  // Split the flat sample bus into one word per channel.
  for (genvar k = 0; k < NCH; k++) begin : g_unpack
    assign w_ch_data[k] = bus.req_data[k*WIDTH +: WIDTH];
  end

  assign w_sel_vld  = bus.req_vld[gnt_q];
  assign w_sel_data = w_ch_data[gnt_q];
  assign w_onehot   = {{(NCH-1){1'b0}}, 1'b1} << gnt_q;

  assign bus.req_rdy  = (state_q == STREAM) ? w_onehot : '0;
  assign bus.busy     = (state_q != IDLE);
  assign bus.m_i_vld  = m_i_vld_q;
  assign bus.m_i_data = m_i_data_q;
  assign bus.res_vld  = res_vld_q;
  assign bus.res_ch   = res_ch_q;
  assign bus.res_data = res_data_q;
  assign bus.err      = err_q;

  // State and output registers; reset leaves channel 0 with first priority.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      rr_q       <= CH_W'(NCH - 1);
      cnt_q      <= '0;
      tcnt_q     <= '0;
      m_i_vld_q  <= 1'b0;
      m_i_data_q <= '0;
      res_vld_q  <= 1'b0;
      res_data_q <= '0;
      res_ch_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      tcnt_q     <= tcnt_d;
      m_i_vld_q  <= m_i_vld_d;
      m_i_data_q <= m_i_data_d;
      res_vld_q  <= res_vld_d;
      res_data_q <= res_data_d;
      res_ch_q   <= res_ch_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic: grant, stream one frame, then collect or time out.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    tcnt_d     = tcnt_q;
    m_i_vld_d  = 1'b0;
    m_i_data_d = m_i_data_q;
    res_vld_d  = 1'b0;
    res_data_d = res_data_q;
    res_ch_d   = res_ch_q;
    err_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A result outside WAIT_RES has no owner; flag it and drop the data.
        err_d = bus.m_o_vld;
        if (w_any) begin
          gnt_d   = w_arb_gnt;
          cnt_d   = '0;
          state_d = STREAM;
        end
      end

      STREAM: begin
        err_d = bus.m_o_vld;
        if (w_sel_vld) begin
          m_i_vld_d  = 1'b1;
          m_i_data_d = w_sel_data;
          if (cnt_q == CW'(L - 1)) begin
            cnt_d   = '0;
            tcnt_d  = '0;
            state_d = WAIT_RES;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      WAIT_RES: begin
        tcnt_d = tcnt_q + TW'(1);
        // A result arriving on the timeout cycle still counts as a result.
        if (bus.m_o_vld) begin
          res_vld_d  = 1'b1;
          res_data_d = bus.m_o_data;
          res_ch_d   = gnt_q;
          rr_d       = gnt_q;
          tcnt_d     = '0;
          state_d    = IDLE;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          rr_d    = gnt_q;
          tcnt_d  = '0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mean_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mean_sched
// Brief    : Directed self-checking bench for mean_sched with a behavioural
//            windowed-mean engine (NCH=4, N=2, TIMEOUT=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mean_sched;
  import mean_sched_pkg::*;

  localparam int WIDTH   = 32;
  localparam int N       = 2;
  localparam int NCH     = 4;
  localparam int TIMEOUT = 8;
  localparam int L       = 4;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  mean_sched_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

  mean_sched #(
    .WIDTH   (WIDTH),
    .N       (N),
    .NCH     (NCH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Requester drive
  logic [NCH-1:0]   drv_vld;
  logic [WIDTH-1:0] drv_data [NCH];

  assign bus.req_vld = drv_vld;

  always_comb begin
    bus.req_data = '0;
    for (int k = 0; k < NCH; k++) begin
      bus.req_data[k*WIDTH +: WIDTH] = drv_data[k];
    end
  end

  // Behavioural mean engine: floor of the sum of L accepted samples / L.
  logic             eng_en;
  logic             inj;
  logic [WIDTH+1:0] acc;
  int               eng_cnt;
  logic             eng_vld;
  logic [WIDTH-1:0] eng_data;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc      <= '0;
      eng_cnt  <= 0;
      eng_vld  <= 1'b0;
      eng_data <= '0;
    end else begin
      eng_vld <= 1'b0;
      if (bus.m_i_vld) begin
        if (eng_cnt == L - 1) begin
          eng_vld  <= eng_en;
          eng_data <= WIDTH'((acc + (WIDTH+2)'(bus.m_i_data)) >> N);
          acc      <= '0;
          eng_cnt  <= 0;
        end else begin
          acc     <= acc + (WIDTH+2)'(bus.m_i_data);
          eng_cnt <= eng_cnt + 1;
        end
      end
    end
  end

  assign bus.m_o_vld  = eng_vld | inj;
  assign bus.m_o_data = eng_data;

  // Observed engine inputs, results and error pulses
  logic [WIDTH-1:0] mi_q [$];
  int               rch_q [$];
  logic [WIDTH-1:0] rdat_q [$];
  int               err_cnt = 0;

  always @(negedge clk) begin
    if (rstn) begin
      if (bus.m_i_vld) mi_q.push_back(bus.m_i_data);
      if (bus.res_vld) begin
        rch_q.push_back(int'(bus.res_ch));
        rdat_q.push_back(bus.res_data);
      end
      if (bus.err) err_cnt++;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer up to nsamp samples on one channel; gap=1 alternates req_vld.
  // Each accepted sample must appear on m_i_data one cycle later, and
  // non-accepting cycles inside the frame must show a bubble.
  task automatic drive_frame(input int ch, input logic [31:0] d0, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [31:0] d3,
                             input bit gap, input int nsamp);
    logic [31:0] d [4];
    logic [31:0] prev_d;
    int  k;
    int  cyc;
    bit  started;
    bit  prev_acc;
    bit  vld;
    bit  acc;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    prev_d = '0; k = 0; cyc = 0; started = 1'b0; prev_acc = 1'b0;
    while (k < nsamp && cyc < 60) begin
      @(negedge clk);
      if (prev_acc) begin
        check_eq("mi_vld", 32'(bus.m_i_vld), 32'd1);
        check_eq("mi_data", bus.m_i_data, prev_d);
      end else if (started) begin
        check_eq("mi_bubble", 32'(bus.m_i_vld), 32'd0);
      end
      vld          = gap ? (cyc % 2 == 0) : 1'b1;
      drv_vld[ch]  = vld;
      drv_data[ch] = d[k];
      if (bus.req_rdy[ch]) started = 1'b1;
      acc = vld && bus.req_rdy[ch];
      @(posedge clk);
      prev_acc = acc;
      if (acc) begin
        prev_d = d[k];
        k++;
      end
      cyc++;
    end
    @(negedge clk);
    if (prev_acc) begin
      check_eq("mi_vld_last", 32'(bus.m_i_vld), 32'd1);
      check_eq("mi_data_last", bus.m_i_data, prev_d);
    end
    drv_vld[ch] = 1'b0;
    check_eq("frame_accepted", 32'(k), 32'(nsamp));
  endtask

  int mb, rb, eb;

  initial begin
    rstn    = 1'b0;
    drv_vld = '0;
    for (int k = 0; k < NCH; k++) drv_data[k] = '0;
    eng_en  = 1'b1;
    inj     = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_req_rdy",  32'(bus.req_rdy), 32'd0);
    check_eq("rst_m_i_vld",  32'(bus.m_i_vld), 32'd0);
    check_eq("rst_m_i_data", bus.m_i_data, 32'd0);
    check_eq("rst_res_vld",  32'(bus.res_vld), 32'd0);
    check_eq("rst_res_ch",   32'(bus.res_ch), 32'd0);
    check_eq("rst_res_data", bus.res_data, 32'd0);
    check_eq("rst_busy",     32'(bus.busy), 32'd0);
    check_eq("rst_err",      32'(bus.err), 32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("idle_busy", 32'(bus.busy), 32'd0);

    // T1: ch0 frame 1,2,3,4 back-to-back -> mean 2
    mb = mi_q.size(); rb = rch_q.size(); eb = err_cnt;
    drive_frame(0, 1, 2, 3, 4, 1'b0, 4);
    check_eq("t1_busy_wait", 32'(bus.busy), 32'd1);
    repeat (10) @(negedge clk);
    check_eq("t1_mi_count", 32'(mi_q.size() - mb), 32'd4);
    check_eq("t1_res_count", 32'(rch_q.size() - rb), 32'd1);
    if (rch_q.size() > rb) begin
      check_eq("t1_res_ch", 32'(rch_q[rb]), 32'd0);
      check_eq("t1_res_data", rdat_q[rb], 32'd2);
    end
    check_eq("t1_busy_after", 32'(bus.busy), 32'd0);
    check_eq("t1_err", 32'(err_cnt - eb), 32'd0);

    // T2: ch1 and ch3 together -> ch1 first, no interleaving
    mb = mi_q.size(); rb = rch_q.size();
    fork
      drive_frame(1, 10, 20, 30, 40, 1'b0, 4);
      drive_frame(3, 8, 8, 8, 8, 1'b0, 4);
    join
    repeat (10) @(negedge clk);
    check_eq("t2_res_count", 32'(rch_q.size() - rb), 32'd2);
    if (rch_q.size() >= rb + 2) begin
      check_eq("t2_first_ch", 32'(rch_q[rb]), 32'd1);
      check_eq("t2_first_data", rdat_q[rb], 32'd25);
      check_eq("t2_second_ch", 32'(rch_q[rb+1]), 32'd3);
      check_eq("t2_second_data", rdat_q[rb+1], 32'd8);
    end
    check_eq("t2_mi_count", 32'(mi_q.size() - mb), 32'd8);
    if (mi_q.size() >= mb + 8) begin
      for (int i = 0; i < 8; i++) begin
        check_eq("t2_mi_order", mi_q[mb+i], (i < 4) ? 32'(10 * (i + 1)) : 32'd8);
      end
    end

    // T3: ch2 with alternating valid -> bubbles, exactly 4 samples, mean 4
    mb = mi_q.size(); rb = rch_q.size(); eb = err_cnt;
    drive_frame(2, 4, 4, 4, 4, 1'b1, 4);
    repeat (10) @(negedge clk);
    check_eq("t3_mi_count", 32'(mi_q.size() - mb), 32'd4);
    check_eq("t3_res_count", 32'(rch_q.size() - rb), 32'd1);
    if (rch_q.size() > rb) begin
      check_eq("t3_res_ch", 32'(rch_q[rb]), 32'd2);
      check_eq("t3_res_data", rdat_q[rb], 32'd4);
    end
    check_eq("t3_err", 32'(err_cnt - eb), 32'd0);

    // T4: engine silent -> err exactly 8 cycles after entering WAIT_RES
    eng_en = 1'b0;
    rb = rch_q.size();
    drive_frame(0, 7, 7, 7, 7, 1'b0, 4);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check_eq("t4_err_early", 32'(bus.err), 32'd0);
    end
    @(negedge clk);
    check_eq("t4_err_pulse", 32'(bus.err), 32'd1);
    check_eq("t4_no_res", 32'(bus.res_vld), 32'd0);
    check_eq("t4_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check_eq("t4_err_single", 32'(bus.err), 32'd0);
    check_eq("t4_res_count", 32'(rch_q.size() - rb), 32'd0);
    eng_en = 1'b1;

    // T4b: rr moved to ch0 on timeout, so ch1 beats ch0
    rb = rch_q.size();
    fork
      drive_frame(0, 6, 6, 6, 6, 1'b0, 4);
      drive_frame(1, 2, 2, 2, 2, 1'b0, 4);
    join
    repeat (10) @(negedge clk);
    check_eq("t4b_res_count", 32'(rch_q.size() - rb), 32'd2);
    if (rch_q.size() >= rb + 2) begin
      check_eq("t4b_first_ch", 32'(rch_q[rb]), 32'd1);
      check_eq("t4b_first_data", rdat_q[rb], 32'd2);
      check_eq("t4b_second_ch", 32'(rch_q[rb+1]), 32'd0);
      check_eq("t4b_second_data", rdat_q[rb+1], 32'd6);
    end

    // T5: spurious m_o_vld during STREAM -> one err, frame still correct
    rb = rch_q.size(); eb = err_cnt;
    fork
      drive_frame(0, 1, 1, 1, 5, 1'b0, 4);
      begin
        int w;
        w = 0;
        while (!bus.req_rdy[0] && w < 20) begin
          @(negedge clk);
          w++;
        end
        if (!bus.req_rdy[0]) begin
          check_eq("t5_stream_wait", 32'd0, 32'd1);
        end else begin
          inj = 1'b1;
          @(negedge clk);
          check_eq("t5_err_pulse", 32'(bus.err), 32'd1);
          inj = 1'b0;
          @(negedge clk);
          check_eq("t5_err_clear", 32'(bus.err), 32'd0);
        end
      end
    join
    repeat (10) @(negedge clk);
    check_eq("t5_err_count", 32'(err_cnt - eb), 32'd1);
    check_eq("t5_res_count", 32'(rch_q.size() - rb), 32'd1);
    if (rch_q.size() > rb) begin
      check_eq("t5_res_ch", 32'(rch_q[rb]), 32'd0);
      check_eq("t5_res_data", rdat_q[rb], 32'd2);
    end

    // T6: reset after 2 samples -> outputs clear at once; rr back to NCH-1
    drive_frame(0, 9, 9, 9, 9, 1'b0, 2);
    rstn = 1'b0;
    #1;
    check_eq("t6_req_rdy",  32'(bus.req_rdy), 32'd0);
    check_eq("t6_m_i_vld",  32'(bus.m_i_vld), 32'd0);
    check_eq("t6_m_i_data", bus.m_i_data, 32'd0);
    check_eq("t6_res_ch",   32'(bus.res_ch), 32'd0);
    check_eq("t6_res_data", bus.res_data, 32'd0);
    check_eq("t6_busy",     32'(bus.busy), 32'd0);
    check_eq("t6_err",      32'(bus.err), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    mb = mi_q.size(); rb = rch_q.size();
    fork
      drive_frame(0, 5, 5, 5, 5, 1'b0, 4);
      drive_frame(1, 3, 3, 3, 3, 1'b0, 4);
    join
    repeat (10) @(negedge clk);
    check_eq("t6_res_count", 32'(rch_q.size() - rb), 32'd2);
    if (rch_q.size() >= rb + 2) begin
      check_eq("t6_first_ch", 32'(rch_q[rb]), 32'd0);
      check_eq("t6_first_data", rdat_q[rb], 32'd5);
      check_eq("t6_second_ch", 32'(rch_q[rb+1]), 32'd1);
      check_eq("t6_second_data", rdat_q[rb+1], 32'd3);
    end
    check_eq("t6_mi_count", 32'(mi_q.size() - mb), 32'd8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop in case the sequence stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/mean_sched.md
Name: mean_sched

Overview:
- Round-robin scheduler that shares one mean engine between NCH sample requesters.
- The mean engine is the cascade's windowed averaging unit: it emits one result per 2**N accepted samples.
- The block grants one channel for a whole frame of 2**N samples and streams that frame into the engine.
- It then waits for the engine result and returns it tagged with the channel index. It sits between the per-channel front ends and the single mean instance in the computing cascade.

Parameters:
- WIDTH, 32, sample and result width in bits.
- N, 1, log2 of frame length; L = 2**N samples per frame.
- NCH, 4, number of requesters (2..16).
- TIMEOUT, 64, cycles allowed in WAIT_RES before abort.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_vld  in  NCH  per-channel sample valid.
- req_data  in  NCH*WIDTH  per-channel samples; channel k occupies bits [k*WIDTH +: WIDTH].
- req_rdy  out  NCH  per-channel accept; one-hot or zero.
- m_i_vld  out  1  sample valid to mean engine.
- m_i_data  out  WIDTH  sample to mean engine.
- m_o_vld  in  1  result valid from mean engine.
- m_o_data  in  WIDTH  result from mean engine.
- res_vld  out  1  one-cycle result pulse.
- res_ch  out  CH_W  channel of result; CH_W = max(1, clog2(NCH)).
- res_data  out  WIDTH  mean result.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle pulse on timeout or on a spurious m_o_vld.

Behaviour:
- Reset (async, rstn=0):
  - State IDLE, all counters 0, rr pointer = NCH-1 (so channel 0 has first priority).
  - req_rdy, m_i_vld, res_vld, err, busy = 0; m_i_data, res_data, res_ch = 0.
- Reset mid-frame drops the partial frame; the engine is reset by the same rstn.
- IDLE:
  - If any req_vld is high, pick the first requester scanning from rr+1 upward with wrap, and latch it as gnt.
  - Next cycle go to STREAM. Grant decision takes exactly 1 cycle.
  - No grant when all req_vld are low.
- STREAM:
  - req_rdy[gnt] = 1, combinational from state; all other req_rdy bits are 0.
  - A transfer occurs when req_vld[gnt] is high.
  - On each transfer, m_i_vld <= 1 and m_i_data <= req_data[gnt], registered (1-cycle latency); cnt increments.
  - A cycle without a transfer drives m_i_vld <= 0 (bubble); the frame continues.
  - The transfer with cnt == L-1 clears cnt and moves to WAIT_RES. req_rdy drops in the following cycle.
  - Requests from other channels are held off; no preemption.
- WAIT_RES:
  - tcnt increments each cycle.
  - On m_o_vld: res_vld <= 1, res_data <= m_o_data, res_ch <= gnt, rr <= gnt, go to IDLE.
  - If tcnt == TIMEOUT-1 with no m_o_vld: err <= 1, no res_vld, rr <= gnt, go to IDLE.
  - If m_o_vld and timeout coincide, the result wins; no err.
- Spurious m_o_vld in IDLE or STREAM: ignored for data, err pulses once.
- Rearbitration: minimum IDLE dwell is 1 cycle. The earliest next grant is the cycle after res_vld.
- Fairness: with all channels requesting continuously, grant order is 0,1,...,NCH-1,0,...
- Widths: cnt is N bits (1 bit min); tcnt is clog2(TIMEOUT) bits. No arithmetic on data; samples pass through unmodified.

Decomposition:
- Package mean_sched_pkg holds:
  - state enum {IDLE, STREAM, WAIT_RES};
  - function ch_w(NCH) returning max(1, clog2);
  - frame length helper L(N).
- One sub-module, rr_arbiter:
  - parameter NCH;
  - inputs req[NCH] and last[CH_W];
  - outputs any and gnt[CH_W];
  - purely combinational priority rotate, instantiated once.

Test Plan:
- NCH=4, N=2, engine = team mean unit. Ch0 sends 1,2,3,4 back-to-back → m_i_vld high 4 cycles, one cycle after each accept; res_vld with res_ch=0, res_data=2 (floor 10/4); busy low after.
- Ch1 and ch3 request simultaneously from reset → ch1 served first, then ch3. Ch3 frame 8,8,8,8 → res_ch=3, res_data=8. No interleaving on m_i_data.
- Ch2 drives req_vld 1,0,1,0,... with data 4,—,4,—,4,—,4 → m_i_vld shows bubbles, exactly 4 samples, res_data=4.
- Engine model never asserts m_o_vld, TIMEOUT=8 → err pulses exactly 8 cycles after entering WAIT_RES; no res_vld; next channel granted.
- Inject m_o_vld while in STREAM → err one cycle; frame completes normally with correct result.
- Assert rstn=0 after 2 samples of a frame → all outputs 0 immediately. After release, a fresh ch0 frame 5,5,5,5 → res_data=5.
